result_tx_sched: RTL and testbench
==================================

RESULT_TX_SCHED -- requirements
Module: result_tx_sched

Interface
REQ-001 SHALL provide parameter N, default 4: result array dimension, giving N*N result RAM banks.
REQ-002 SHALL provide parameter C_AW, default 8: result RAM address width.
REQ-003 SHALL provide port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL provide port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port start, input, 1: pulse that begins a readout (driven from calc_done).
REQ-006 SHALL provide port seg_length, input, 8: words per bank, sampled at start.
REQ-007 SHALL provide port ram_c_addr, output, C_AW: shared read address to all result banks.
REQ-008 SHALL provide port ram_c_rden_all, output, N*N: one-hot bank read enable; bank index = i*N+j.
REQ-009 SHALL provide port ram_c_data, input, N*N*32: flattened bank read data; bank k occupies bits [32k+31:32k].
REQ-010 SHALL provide port uart_tx_data, output, 8: byte to transmit.
REQ-011 SHALL provide port uart_send_data, output, 1: one-cycle transmit strobe.
REQ-012 SHALL provide port uart_tx_done, input, 1: one-cycle byte-complete pulse from the UART.
REQ-013 SHALL provide port busy, output, 1: high from the cycle after an accepted start until done.
REQ-014 SHALL provide port done, output, 1: one-cycle pulse at readout end (data_response_done).

Function
REQ-015 SHALL use states IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_TX, NEXT, FIN.
REQ-016 IDLE: start=1 SHALL latch seg_length, clear bank and address counters, and go to RD_REQ; start=1 with latched seg_length=0 SHALL go directly to FIN.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 RD_REQ SHALL drive ram_c_addr=addr_cnt and ram_c_rden_all=one-hot(bank_cnt) for exactly one cycle; rden SHALL be 0 in every other state.
REQ-019 SHALL assume 1-cycle RAM read latency: RD_WAIT lasts one cycle, then LOAD captures the selected bank's 32-bit word into a shift register.
REQ-020 Byte order SHALL be MSB first: bits [31:24], [23:16], [15:8], [7:0].
REQ-021 SEND SHALL present the current byte on uart_tx_data, pulse uart_send_data for one cycle, and go to WAIT_TX.
REQ-022 WAIT_TX SHALL hold uart_tx_data stable until uart_tx_done; after done it SHALL return to SEND if bytes remain in the word, else go to NEXT.
REQ-023 SHALL ignore uart_tx_done outside WAIT_TX.
REQ-024 NEXT SHALL increment addr_cnt; at addr_cnt=seg_length-1 it SHALL wrap addr_cnt to 0 and increment bank_cnt; at the last bank (N*N-1) and last address it SHALL go to FIN, else to RD_REQ.
REQ-025 Transmit order SHALL be bank-major: bank 0 addresses 0..L-1, then bank 1, and so on, for a total of 4*L*N*N bytes.
REQ-026 FIN SHALL pulse done for one cycle and return to IDLE; busy SHALL fall in the same cycle.
REQ-027 Counters SHALL be sized for 255 addresses and N*N banks without overflow; comparisons SHALL use the latched length.

Reset
REQ-028 rst=1 SHALL force IDLE, zero all counters and the shift register, and drive every output to 0 on the next edge, including mid-readout; no done pulse SHALL follow.
REQ-029 rst SHALL take priority over simultaneous start or uart_tx_done.

Configuration
REQ-030 With RESULT_TX_CKSUM_EN defined, the block SHALL keep a running XOR of all transmitted data bytes and, after the last data byte, send one checksum byte via SEND/WAIT_TX before FIN.
REQ-031 With seg_length=0 and RESULT_TX_CKSUM_EN defined, the checksum byte SHALL be 0x00 and SHALL still be sent.
REQ-032 Without RESULT_TX_CKSUM_EN, the block SHALL contain no checksum logic and the stream SHALL be data bytes only.

Structure
REQ-033 N, the data width (32), and the state enum type SHALL live in shared package fumpy_pkg.
REQ-034 The 32-to-8 shift register and byte counter SHALL form sub-module word_byte_ser (load, shift, last_byte, byte_out); sequencing SHALL stay in result_tx_sched.

Verification
REQ-035 N=2, L=1, bank k word = 0x11223344+k, UART done 3 cycles after each send -> 16 bytes: 11 22 33 44 11 22 33 45 ..., then a single done pulse.
REQ-036 L=0 -> done 2 cycles after start, zero send strobes, no rden activity.
REQ-037 N=2, L=3 -> rden/addr sequence (bank0,a0..a2),(bank1,a0..a2)...; exactly one rden cycle per word.
REQ-038 rst asserted after the 5th byte -> all outputs 0 next cycle, no done; a new start gives a full correct stream.
REQ-039 start pulsed while busy, and spurious uart_tx_done in SEND/RD_WAIT -> no effect on stream or count.
REQ-040 RESULT_TX_CKSUM_EN, N=2, L=1, words as in REQ-035 -> 17th byte equals the XOR of the 16 data bytes, then done.

Source files
------------

// File: rtl/fumpy_pkg.sv
// Shared definitions for the result readout path: array size default, word width
// and the transmit scheduler state encoding.
package fumpy_pkg;

  localparam int FUMPY_N = 4;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    LOAD    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5,
    NEXT    = 3'd6,
    FIN     = 3'd7
  } tx_state_t;

endpackage

// File: rtl/word_byte_ser.sv
// Splits one result word into bytes, most significant byte first; the caller
// decides when to load and when to advance.
module word_byte_ser
  import fumpy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  output logic [7:0]        byte_out,
  output logic              last_byte
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] r_shReg;
  logic [CW-1:0]     r_byteCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shReg   <= '0;
      r_byteCnt <= '0;
    end else if (load) begin
      r_shReg   <= din;
      r_byteCnt <= '0;
    end else if (shift) begin
      r_shReg   <= {r_shReg[DATA_W-9:0], 8'h00};
      r_byteCnt <= r_byteCnt + 1'b1;
    end
  end

  assign byte_out  = r_shReg[DATA_W-1 -: 8];
  assign last_byte = (r_byteCnt == CW'(NBYTES - 1));

endmodule

// File: rtl/result_tx_sched.sv
// Streams every result bank over the UART, bank-major, one byte per handshake.
// Define RESULT_TX_CKSUM_EN to append an XOR checksum byte after the data.
module result_tx_sched
  import fumpy_pkg::*;
#(
  parameter int N    = FUMPY_N,
  parameter int C_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               seg_length,
  output logic [C_AW-1:0]          ram_c_addr,
  output logic [N*N-1:0]           ram_c_rden_all,
  input  logic [N*N*DATA_W-1:0]    ram_c_data,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_send_data,
  input  logic                     uart_tx_done,
  output logic                     busy,
  output logic                     done
);

  localparam int NB = N * N;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BANK = BW'(NB - 1);

  tx_state_t         r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_addr;
  logic [BW-1:0]     r_bank;
  logic              r_done;
  logic              r_busy;

  logic              w_load;
  logic              w_shift;
  logic              w_lastByte;
  logic [7:0]        w_byte;
  logic [7:0]        w_txByte;
  logic [DATA_W-1:0] w_word;

`ifdef RESULT_TX_CKSUM_EN
  logic [7:0]        r_cksum;
  logic              r_ckPhase;
`endif

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NB; k++) begin
      if (r_bank == BW'(k)) w_word = ram_c_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_load  = (r_state == LOAD);
  assign w_shift = (r_state == WAIT_TX) && uart_tx_done && !w_lastByte;

  word_byte_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .din       (w_word),
    .shift     (w_shift),
    .byte_out  (w_byte),
    .last_byte (w_lastByte)
  );

`ifdef RESULT_TX_CKSUM_EN
  assign w_txByte = r_ckPhase ? r_cksum : w_byte;
`else
  assign w_txByte = w_byte;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_addr  <= '0;
      r_bank  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef RESULT_TX_CKSUM_EN
      r_cksum   <= '0;
      r_ckPhase <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_len  <= seg_length;
            r_addr <= '0;
            r_bank <= '0;
`ifdef RESULT_TX_CKSUM_EN
            r_cksum   <= '0;
            r_ckPhase <= (seg_length == 8'd0);
            r_state   <= (seg_length == 8'd0) ? SEND : RD_REQ;
`else
            r_state   <= (seg_length == 8'd0) ? FIN : RD_REQ;
`endif
          end
        end
        RD_REQ:  r_state <= RD_WAIT;
        RD_WAIT: r_state <= LOAD;
        LOAD:    r_state <= SEND;
        SEND:    r_state <= WAIT_TX;
        WAIT_TX: begin
          if (uart_tx_done) begin
`ifdef RESULT_TX_CKSUM_EN
            if (r_ckPhase) begin
              r_state <= FIN;
            end else begin
              r_cksum <= r_cksum ^ w_byte;
              r_state <= w_lastByte ? NEXT : SEND;
            end
`else
            r_state <= w_lastByte ? NEXT : SEND;
`endif
          end
        end
        NEXT: begin
          // Length is at least one here; a zero length never leaves IDLE for RD_REQ.
          if (r_addr == r_len - 8'd1) begin
            r_addr <= '0;
            if (r_bank == LAST_BANK) begin
`ifdef RESULT_TX_CKSUM_EN
              r_ckPhase <= 1'b1;
              r_state   <= SEND;
`else
              r_state   <= FIN;
`endif
            end else begin
              r_bank  <= r_bank + 1'b1;
              r_state <= RD_REQ;
            end
          end else begin
            r_addr  <= r_addr + 8'd1;
            r_state <= RD_REQ;
          end
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_c_rden_all = '0;
    if (r_state == RD_REQ) ram_c_rden_all[r_bank] = 1'b1;
  end

  assign ram_c_addr     = C_AW'(r_addr);
  assign uart_send_data = (r_state == SEND);
  assign uart_tx_data   = ((r_state == SEND) || (r_state == WAIT_TX)) ? w_txByte : 8'h00;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_result_tx_sched.sv
// Randomized bench for result_tx_sched with a RAM model, a UART responder and a
// stream-level reference model (also covers the RESULT_TX_CKSUM_EN build).
module tb_result_tx_sched;

  localparam int N  = 2;
  localparam int NB = N * N;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [7:0]      seg_length;
  logic [AW-1:0]   ram_c_addr;
  logic [NB-1:0]   ram_c_rden_all;
  logic [NB*32-1:0] ram_c_data;
  logic [7:0]      uart_tx_data;
  logic            uart_send_data;
  logic            uart_tx_done;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [NB][256];
  logic [31:0] ramOut [NB];

  logic [7:0] gotBytes [$];
  int         rdenLog [$];
  logic [7:0] expBytes [$];
  int         expRden [$];

  logic uDone = 1'b0;
  logic sDone = 1'b0;
  bit   spurEn = 1'b0;
  bit   rdenPrev = 1'b0;
  int   uCnt = 0;
  int   stabErr = 0;
  logic [7:0] respLast = 8'h00;
  int   monBank;

  result_tx_sched #(.N(N), .C_AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seg_length     (seg_length),
    .ram_c_addr     (ram_c_addr),
    .ram_c_rden_all (ram_c_rden_all),
    .ram_c_data     (ram_c_data),
    .uart_tx_data   (uart_tx_data),
    .uart_send_data (uart_send_data),
    .uart_tx_done   (uart_tx_done),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Result banks with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (ram_c_rden_all[k]) ramOut[k] <= mem[k][ram_c_addr];
    end
  end

  always_comb begin
    ram_c_data = '0;
    for (int k = 0; k < NB; k++) ram_c_data[k*32 +: 32] = ramOut[k];
  end

  // UART answers each strobe three cycles later; data must still hold the sent byte then.
  always @(negedge clk) begin
    uDone = 1'b0;
    if (uCnt > 0) begin
      uCnt--;
      if (uCnt == 0) begin
        uDone = 1'b1;
        if (busy && uart_tx_data !== respLast) stabErr++;
      end
    end
    if (uart_send_data) begin
      uCnt     = 3;
      respLast = uart_tx_data;
    end
  end

  always @(negedge clk) begin
    sDone    = spurEn && (uart_send_data || rdenPrev);
    rdenPrev = (ram_c_rden_all != '0);
  end

  assign uart_tx_done = uDone | sDone;

  always @(negedge clk) begin
    if (uart_send_data) gotBytes.push_back(uart_tx_data);
    if (ram_c_rden_all != '0) begin
      monBank = -1;
      for (int k = 0; k < NB; k++) begin
        if (ram_c_rden_all[k]) monBank = (monBank == -1) ? k : 99;
      end
      rdenLog.push_back(monBank * 256 + int'(ram_c_addr));
    end
  end

  task automatic buildExp(input int len);
    logic [7:0] ck;
    logic [7:0] b;
    ck = 8'h00;
    expBytes.delete();
    expRden.delete();
    for (int bk = 0; bk < NB; bk++) begin
      for (int a = 0; a < len; a++) begin
        expRden.push_back(bk * 256 + a);
        for (int s = 3; s >= 0; s--) begin
          b = 8'(mem[bk][a] >> (8 * s));
          expBytes.push_back(b);
          ck = ck ^ b;
        end
      end
    end
`ifdef RESULT_TX_CKSUM_EN
    expBytes.push_back(ck);
`endif
  endtask

  task automatic fillRandom();
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = $urandom;
  endtask

  task automatic runStream(input int len, input string tag, input bit busyStart);
    int b0, r0, s0, limit, doneSeen, extraDone, badIdx;
    b0 = gotBytes.size();
    r0 = rdenLog.size();
    s0 = stabErr;
    doneSeen = 0;
    extraDone = 0;
    buildExp(len);
    @(negedge clk);
    start = 1'b1;
    seg_length = 8'(len);
    @(negedge clk);
    start = 1'b0;
    seg_length = 8'($urandom);
    limit = (len * NB * 4 + 1) * 8 + len * NB * 6 + 50;
    for (int i = 0; i < limit && doneSeen == 0; i++) begin
      start = busyStart && (i == 10 || i == 11);
      seg_length = 8'($urandom);
      @(negedge clk);
      if (done) doneSeen = 1;
    end
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) extraDone++;
    end

    checks++;
    if (doneSeen !== 1) begin
      errors++;
      $display("[TB] FAIL %s done: got %0d required 1 (timeout)", tag, doneSeen);
    end
    checks++;
    if (gotBytes.size() - b0 !== expBytes.size()) begin
      errors++;
      $display("[TB] FAIL %s byte count: got %0d required %0d", tag, gotBytes.size() - b0, expBytes.size());
    end
    badIdx = -1;
    for (int i = 0; i < expBytes.size() && badIdx < 0; i++) begin
      if (b0 + i >= gotBytes.size() || gotBytes[b0 + i] !== expBytes[i]) badIdx = i;
    end
    checks++;
    if (badIdx >= 0) begin
      errors++;
      $display("[TB] FAIL %s byte[%0d]: got %h required %h", tag, badIdx,
               (b0 + badIdx < gotBytes.size()) ? gotBytes[b0 + badIdx] : 8'hxx, expBytes[badIdx]);
    end
    checks++;
    if (rdenLog.size() - r0 !== expRden.size()) begin
      errors++;
      $display("[TB] FAIL %s rden count: got %0d required %0d", tag, rdenLog.size() - r0, expRden.size());
    end
    badIdx = -1;
    for (int i = 0; i < expRden.size() && badIdx < 0; i++) begin
      if (r0 + i >= rdenLog.size() || rdenLog[r0 + i] !== expRden[i]) badIdx = i;
    end
    checks++;
    if (badIdx >= 0) begin
      errors++;
      $display("[TB] FAIL %s rden[%0d] bank*256+addr: got %0d required %0d", tag, badIdx,
               (r0 + badIdx < rdenLog.size()) ? rdenLog[r0 + badIdx] : -1, expRden[badIdx]);
    end
    checks++;
    if (stabErr - s0 !== 0) begin
      errors++;
      $display("[TB] FAIL %s tx_data hold: got %0d unstable bytes required 0", tag, stabErr - s0);
    end
    checks++;
    if (extraDone !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s after done: got extra=%0d busy=%0d required 0/0", tag, extraDone, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    seg_length = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, uart_send_data} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset flags: got %b required 000", {done, busy, uart_send_data});
    end
    checks++;
    if (uart_tx_data !== 8'h00 || ram_c_addr !== '0 || ram_c_rden_all !== '0) begin
      errors++;
      $display("[TB] FAIL reset buses: got data=%h addr=%h rden=%b required 0", uart_tx_data, ram_c_addr, ram_c_rden_all);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    for (int k = 0; k < NB; k++) mem[k][0] = 32'h11223344 + 32'(k);
    runStream(1, "basic_L1", 1'b0);
  endtask

  task automatic test_zero_len();
    int b0, r0, firstDone, busy1, busy2;
    b0 = gotBytes.size();
    r0 = rdenLog.size();
    firstDone = 0;
    busy1 = 0;
    busy2 = 0;
    @(negedge clk);
    start = 1'b1;
    seg_length = 8'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) busy1 = int'(busy);
      if (i == 2) busy2 = int'(busy);
      if (done && firstDone == 0) firstDone = i;
    end
    checks++;
    if (rdenLog.size() - r0 !== 0) begin
      errors++;
      $display("[TB] FAIL zero_len rden: got %0d cycles required 0", rdenLog.size() - r0);
    end
`ifdef RESULT_TX_CKSUM_EN
    checks++;
    if (gotBytes.size() - b0 !== 1 || gotBytes[gotBytes.size() - 1] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL zero_len cksum: got %0d sends last=%h required 1 of 00", gotBytes.size() - b0, gotBytes[gotBytes.size() - 1]);
    end
    checks++;
    if (firstDone == 0) begin
      errors++;
      $display("[TB] FAIL zero_len done: got none required one pulse");
    end
`else
    checks++;
    if (gotBytes.size() - b0 !== 0) begin
      errors++;
      $display("[TB] FAIL zero_len sends: got %0d required 0", gotBytes.size() - b0);
    end
    checks++;
    if (firstDone !== 2) begin
      errors++;
      $display("[TB] FAIL zero_len done latency: got %0d required 2", firstDone);
    end
    checks++;
    if (busy1 !== 1 || busy2 !== 0) begin
      errors++;
      $display("[TB] FAIL zero_len busy: got %0d%0d required 10", busy1, busy2);
    end
`endif
  endtask

  task automatic test_rden_seq();
    fillRandom();
    runStream(3, "rden_L3", 1'b0);
  endtask

  task automatic test_spurious();
    spurEn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      fillRandom();
      runStream($urandom_range(1, 6), $sformatf("spur%0d", t), 1'b1);
    end
    spurEn = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b0, doneAfter, got;
    fillRandom();
    b0 = gotBytes.size();
    @(negedge clk);
    start = 1'b1;
    seg_length = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && gotBytes.size() < b0 + 5; i++) @(negedge clk);
    got = gotBytes.size() - b0;
    checks++;
    if (got !== 5) begin
      errors++;
      $display("[TB] FAIL reset_mid progress: got %0d bytes required 5", got);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, busy, uart_send_data} !== 3'b000 || uart_tx_data !== 8'h00 ||
        ram_c_addr !== '0 || ram_c_rden_all !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid outputs: got d=%b b=%b s=%b data=%h addr=%h rden=%b required all 0",
               done, busy, uart_send_data, uart_tx_data, ram_c_addr, ram_c_rden_all);
    end
    rst = 1'b0;
    doneAfter = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneAfter++;
    end
    checks++;
    if (doneAfter !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid done: got %0d pulses required 0", doneAfter);
    end
    runStream(2, "after_reset", 1'b0);
  endtask

  task automatic test_max_len();
    fillRandom();
    runStream(255, "max_L255", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_rden_seq();
    test_spurious();
    test_reset_mid();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
